mont_exp_ctrl: RTL and testbench

Sequencer that computes a modular exponentiation result = X^E mod M. It drives one shared `montgomery` multiplier instance with left-to-right square-and-multiply. Operands are kept in the Montgomery domain throughout and converted in and out with extra multiplier passes. The block sits between the host/register interface and the multiplier, and owns the multiplier's start/operand bus.

---
 rtl/mont_exp_ctrl.sv | 144 ++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right square-and-multiply in the
// Montgomery domain over one shared external Montgomery multiplier.
module mont_exp_ctrl #(
  parameter int N_WIDTH = 1024,
  parameter int E_WIDTH = 1024,
  parameter int L_WIDTH = 11
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_WIDTH-1:0] in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [L_WIDTH-1:0] in_e_len,
  input  logic [N_WIDTH-1:0] in_m,
  input  logic [N_WIDTH-1:0] in_r,
  input  logic [N_WIDTH-1:0] in_r2,
  output logic [N_WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [N_WIDTH-1:0] mm_a,
  output logic [N_WIDTH-1:0] mm_b,
  output logic [N_WIDTH-1:0] mm_m,
  input  logic [N_WIDTH-1:0] mm_result,
  input  logic               mm_done
);

  localparam int I_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [L_WIDTH-1:0] T_MAX = L_WIDTH'(E_WIDTH);
  localparam logic [N_WIDTH-1:0] ONE   = N_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_TO_MONT, S_W_TO, S_SQUARE, S_W_SQ, S_MULT, S_W_MUL,
    S_NEXT, S_FROM_MONT, S_W_FROM, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [N_WIDTH-1:0] r_x, r_m, r_r, r_r2, r_xt, r_a, r_result;
  logic [E_WIDTH-1:0] r_e;
  logic [L_WIDTH-1:0] r_t;
  logic [I_W-1:0]     r_idx;
  logic               r_mm_start;
  logic [N_WIDTH-1:0] r_mm_a, r_mm_b;

  logic               w_issue;
  logic [N_WIDTH-1:0] w_op_a, w_op_b;
  logic [L_WIDTH-1:0] w_t_in, w_t_m1;

  assign w_t_in = (in_e_len > T_MAX) ? T_MAX : in_e_len;
  assign w_t_m1 = r_t - L_WIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; mm_done only matters in the wait states
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_TO_MONT;
      S_TO_MONT:   w_state_nxt = S_W_TO;
      S_W_TO:      if (mm_done) w_state_nxt = (r_t == '0) ? S_FROM_MONT : S_SQUARE;
      S_SQUARE:    w_state_nxt = S_W_SQ;
      S_W_SQ:      if (mm_done) w_state_nxt = r_e[r_idx] ? S_MULT : S_NEXT;
      S_MULT:      w_state_nxt = S_W_MUL;
      S_W_MUL:     if (mm_done) w_state_nxt = S_NEXT;
      S_NEXT:      w_state_nxt = (r_idx == '0) ? S_FROM_MONT : S_SQUARE;
      S_FROM_MONT: w_state_nxt = S_W_FROM;
      S_W_FROM:    if (mm_done) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output / operand-select logic
  always_comb begin
    w_issue = 1'b0;
    w_op_a  = r_a;
    w_op_b  = r_a;
    done    = (r_state == S_DONE);
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_TO_MONT:   begin w_issue = 1'b1; w_op_a = r_x; w_op_b = r_r2; end
      S_SQUARE:    begin w_issue = 1'b1; w_op_a = r_a; w_op_b = r_a;  end
      S_MULT:      begin w_issue = 1'b1; w_op_a = r_a; w_op_b = r_xt; end
      S_FROM_MONT: begin w_issue = 1'b1; w_op_a = r_a; w_op_b = ONE;  end
      default:     ;
    endcase
  end

  // Datapath: operands load in the issue state, mm_start fires in the following cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x        <= '0;
      r_e        <= '0;
      r_m        <= '0;
      r_r        <= '0;
      r_r2       <= '0;
      r_t        <= '0;
      r_xt       <= '0;
      r_a        <= '0;
      r_idx      <= '0;
      r_result   <= '0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
    end else begin
      r_mm_start <= w_issue;
      if (w_issue) begin
        r_mm_a <= w_op_a;
        r_mm_b <= w_op_b;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_x  <= in_x;
          r_e  <= in_e;
          r_m  <= in_m;
          r_r  <= in_r;
          r_r2 <= in_r2;
          r_t  <= w_t_in;
        end
        S_W_TO: if (mm_done) begin
          r_xt  <= mm_result;
          r_a   <= r_r;
          r_idx <= w_t_m1[I_W-1:0];
        end
        S_W_SQ, S_W_MUL: if (mm_done) r_a <= mm_result;
        S_NEXT:   if (r_idx != '0) r_idx <= r_idx - I_W'(1);
        S_W_FROM: if (mm_done) r_result <= mm_result;
        default:  ;
      endcase
    end
  end

  assign result   = r_result;
  assign mm_start = r_mm_start;
  assign mm_a     = r_mm_a;
  assign mm_b     = r_mm_b;
  assign mm_m     = r_m;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier, directed requests,
// scoreboard of expected results checked by an independent monitor on done.
module tb_mont_exp_ctrl;
  localparam int N = 1024;
  localparam int E = 1024;
  localparam int L = 11;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [E-1:0] in_e = '0;
  logic [L-1:0] in_e_len = '0;
  logic [N-1:0] result, mm_a, mm_b, mm_m;
  logic [N-1:0] mm_result = '0;
  logic done, busy, mm_start;
  logic mm_done = 1'b0;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.N_WIDTH(N), .E_WIDTH(E), .L_WIDTH(L)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e),
    .in_e_len(in_e_len), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy), .mm_start(mm_start),
    .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_result(mm_result), .mm_done(mm_done)
  );

  // ---------------- golden arithmetic ----------------
  function automatic logic [N-1:0] addmod(input logic [N-1:0] a, b, m);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, b, m);
    logic [N-1:0] r;
    r = '0;
    for (int i = N-1; i >= 0; i--) begin
      r = addmod(r, r, m);
      if (b[i]) r = addmod(r, a, m);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] powmod(input logic [N-1:0] x, input logic [E-1:0] e,
                                          input int t, input logic [N-1:0] m);
    logic [N-1:0] r;
    r = (m == N'(1)) ? '0 : N'(1);
    for (int i = t-1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, x, m);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rmod(input logic [N-1:0] m);
    logic [N-1:0] r;
    r = N'(1);
    for (int i = 0; i < N; i++) r = addmod(r, r, m);
    return r;
  endfunction

  function automatic logic [N-1:0] mont(input logic [N-1:0] a, b, m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b0, b};
      if (t[0]) t = t + {2'b0, m};
      t = t >> 1;
    end
    if (t >= {2'b0, m}) t = t - {2'b0, m};
    return t[N-1:0];
  endfunction

  // ---------------- multiplier model ----------------
  logic [N-1:0] mm_q;
  int mm_cnt = 0;
  always @(posedge clk) begin
    if (!resetn) begin
      mm_cnt  <= 0;
      mm_done <= 1'b0;
    end else begin
      mm_done <= 1'b0;
      if (mm_start) begin
        mm_q   <= mont(mm_a, mm_b, mm_m);
        mm_cnt <= LAT;
      end else if (mm_cnt != 0) begin
        mm_cnt <= mm_cnt - 1;
        if (mm_cnt == 1) begin
          mm_done   <= 1'b1;
          mm_result <= mm_q;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic [N-1:0] res; int nmm; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0;
  int n_done = 0, mm_cnt_op = 0, stab_viol = 0, busy_bad = 0, mm_m_bad = 0;
  logic [N-1:0] cur_m, cur_r2, cur_xt, wa, wb;
  logic [127:0] kinds = '0;
  logic in_wait = 1'b0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      mm_cnt_op = 0;
      in_wait   = 1'b0;
    end else begin
      if (mm_start) begin
        mm_cnt_op++;
        if (mm_m !== cur_m) mm_m_bad++;
        if (mm_b == cur_r2)     kinds = {kinds[119:0], "T"};
        else if (mm_b == N'(1)) kinds = {kinds[119:0], "F"};
        else if (mm_a == mm_b)  kinds = {kinds[119:0], "S"};
        else if (mm_b == cur_xt) kinds = {kinds[119:0], "M"};
        else                    kinds = {kinds[119:0], "X"};
        in_wait = 1'b1;
        wa = mm_a;
        wb = mm_b;
      end else if (in_wait && (mm_a !== wa || mm_b !== wb)) stab_viol++;
      if (in_wait && !busy) busy_bad++;
      if (mm_done) in_wait = 1'b0;
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_done: result %0h with no request pending", result[127:0]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("mm_count", N'(mm_cnt_op), N'(e.nmm));
          chk("busy_at_done", N'(busy), N'(1));
        end
        mm_cnt_op = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [N-1:0] x, input logic [E-1:0] e, input int t,
                       input logic [N-1:0] m, input logic [N-1:0] exp_res, input int nmm);
    logic [N-1:0] rm;
    exp_t ex;
    rm = rmod(m);
    cur_m  = m;
    cur_r2 = mulmod(rm, rm, m);
    cur_xt = mulmod(x, rm, m);
    ex.res = exp_res;
    ex.nmm = nmm;
    exp_q.push_back(ex);
    kinds = '0;
    in_x = x; in_e = e; in_e_len = L'(t); in_m = m; in_r = rm; in_r2 = cur_r2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", N'(busy), N'(1));
  endtask

  task automatic wait_idle(input int nd0);
    int k;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin
      n_chk++; n_err++;
      $display("FAIL timeout: busy still %0d after %0d cycles", busy, k);
    end
    chk("done_once", N'(n_done - nd0), N'(1));
    chk("queue_empty", N'(exp_q.size()), N'(0));
    @(posedge clk); #1;
  endtask

  logic [N-1:0] m0, m1, g4;
  logic [E-1:0] e4;
  logic [127:0] k_exp;
  int nd, hold_bad;

  initial begin
    m0 = (N'(1) << (N-1)) + N'(1155);
    for (int i = 0; i < N/32; i++) m1[i*32 +: 32] = $urandom;
    m1[N-1] = 1'b1;
    m1[0]   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, '0);
    chk("rst_flags", N'({done, busy, mm_start}), '0);
    chk("rst_mm_ops", mm_a | mm_b | mm_m, '0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 1: t=0 -> 1
    nd = n_done; stab_viol = 0;
    issue(N'(3), E'(0), 0, m0, N'(1), 2);
    wait_idle(nd);
    chk("busy_low_after", N'(busy), N'(0));

    // 2: E=1
    nd = n_done;
    issue(N'(16'h1234), E'(1), 1, m0, N'(16'h1234), 4);
    wait_idle(nd);

    // 3: E=0b101 -> 32, op order and operand stability
    nd = n_done; stab_viol = 0;
    issue(N'(2), E'(5), 3, m0, N'(32), 7);
    wait_idle(nd);
    k_exp = "TSMSSMF";
    chk("op_order", N'(kinds), N'(k_exp));
    chk("operand_stable", N'(stab_viol), N'(0));

    // 4: random modulus, 3^65537
    g4 = powmod(N'(3), E'(65537), 17, m1);
    nd = n_done;
    issue(N'(3), E'(65537), 17, m1, g4, 21);
    wait_idle(nd);
    e4 = E'(65537);
    e4[E-1:17] = {(E-17)/16 + 1{16'hA5C3}};
    nd = n_done;
    issue(N'(3), e4, 17, m1, g4, 21);
    wait_idle(nd);

    // 5: start while busy is ignored; result holds until the next request completes
    nd = n_done;
    issue(N'(16'h1234), E'(1), 1, m0, N'(16'h1234), 4);
    repeat (3) @(posedge clk);
    #1;
    in_x = N'(7); in_e = E'(3); in_e_len = L'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(nd);
    chk("ignored_start_idle", N'(busy), N'(0));
    nd = n_done; hold_bad = 0;
    issue(N'(2), E'(5), 3, m0, N'(32), 7);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!done && result !== N'(16'h1234)) hold_bad++;
    end
    chk("result_hold", N'(hold_bad), N'(0));
    wait_idle(nd);

    // 6: reset during the first square wait
    nd = n_done;
    cur_m = m0;
    in_x = N'(2); in_e = E'(5); in_e_len = L'(3); in_m = m0;
    in_r = rmod(m0); in_r2 = mulmod(in_r, in_r, m0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && mm_cnt_op < 2; k++) @(negedge clk);
    chk("reached_sq", N'(mm_cnt_op), N'(2));
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", N'(busy), N'(0));
    chk("abort_result", result, '0);
    chk("abort_start_done", N'({mm_start, done}), '0);
    resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", N'(n_done - nd), N'(0));
    nd = n_done;
    issue(N'(2), E'(5), 3, m0, N'(32), 7);
    wait_idle(nd);

    chk("mm_m_match", N'(mm_m_bad), N'(0));
    chk("busy_in_wait", N'(busy_bad), N'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d errors so far", n_err);
    $fatal(1);
  end

endmodule
